pulsegen_run_ctrl: RTL

Run controller for the 20-channel pulse loop. It owns the timing table: per-channel begin/end counts, `io_init`, `max_count` and the repeat count. The table is double-buffered, with host writes landing in a shadow bank and copied to the active bank only at safe points. The block replaces the manual `sw[1:0]` control with a command-driven state machine that arms, starts, stops and counts pulse periods, and drives the loop's enable/run inputs and table ports directly.

---
 rtl/pulsegen_run_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pulsegen_run_ctrl.sv
// pulsegen_run_ctrl
// Command-driven run controller for the NCH-channel pulse loop. Holds a
// double-buffered timing table (shadow bank written by the host, active bank
// driven to the loop), sequences IDLE/ARMED/RUN/DONE from ARM/START/STOP/DISARM
// commands, mirrors the loop's period counter and counts completed periods.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   cfg_we/addr/wdata   shadow-bank write port
//                       (0..NCH-1 beg, NCH..2NCH-1 end, 2NCH io_init,
//                        2NCH+1 max_count, 2NCH+2 repeat; higher addresses ignored)
//   cmd_valid/op/ready  command handshake (0 ARM, 1 START, 2 STOP, 3 DISARM)
//   sw_en, sw_run       loop enable / run inputs
//   cnt_beg, cnt_end    active per-channel begin / end counts
//   io_init, max_count  active idle levels and period - 1
//   cycles_done         completed periods since the last START
//   done                repeat target reached
//   cmd_err             one-cycle pulse on an illegal command
module pulsegen_run_ctrl #(
  parameter int NCH    = 20,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [5:0]                   cfg_addr,
  input  logic [DATA_W-1:0]            cfg_wdata,
  input  logic                         cmd_valid,
  input  logic [1:0]                   cmd_op,
  output logic                         cmd_ready,
  output logic                         sw_en,
  output logic                         sw_run,
  output logic [NCH-1:0][DATA_W-1:0]   cnt_beg,
  output logic [NCH-1:0][DATA_W-1:0]   cnt_end,
  output logic [DATA_W-1:0]            io_init,
  output logic [DATA_W-1:0]            max_count,
  output logic [DATA_W-1:0]            cycles_done,
  output logic                         done,
  output logic                         cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_ARM    = 2'd0;
  localparam logic [1:0] OP_START  = 2'd1;
  localparam logic [1:0] OP_STOP   = 2'd2;
  localparam logic [1:0] OP_DISARM = 2'd3;

  localparam logic [5:0] ADDR_IO  = 6'(2 * NCH);
  localparam logic [5:0] ADDR_MAX = 6'(2 * NCH + 1);
  localparam logic [5:0] ADDR_RPT = 6'(2 * NCH + 2);

  state_t state, state_nxt;

  // Shadow bank (host side)
  logic [NCH-1:0][DATA_W-1:0] sh_beg;
  logic [NCH-1:0][DATA_W-1:0] sh_end;
  logic [DATA_W-1:0]          sh_io;
  logic [DATA_W-1:0]          sh_max;
  logic [DATA_W-1:0]          sh_rpt;

  // Active repeat target (not a port, but part of the active bank)
  logic [DATA_W-1:0]          act_rpt;

  logic              pending;
  logic [DATA_W-1:0] m;
  logic              init_cyc;

  logic              accept;
  logic              cmd_ill;
  logic              cmd_win;
  logic              start_go;
  logic              disarm_go;
  logic              boundary;
  logic              commit;
  logic [DATA_W-1:0] cyc_inc;

  assign accept    = cmd_valid && cmd_ready;
  assign cyc_inc   = cycles_done + DATA_W'(1);
  // The loop spends its first RUN cycle on init with count 0; that cycle is
  // never a period boundary even when max_count is 0.
  assign boundary  = (state == S_RUN) && !init_cyc && (m == max_count);
  assign cmd_win   = accept && !cmd_ill;
  assign start_go  = cmd_win && (cmd_op == OP_START);
  assign disarm_go = cmd_win && (cmd_op == OP_DISARM);
  assign commit    = start_go || (boundary && pending);

  always_comb begin
    state_nxt = state;
    cmd_ill   = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (cmd_op == OP_ARM) state_nxt = S_ARMED;
          else                  cmd_ill   = 1'b1;
        end
        S_ARMED: begin
          if (cmd_op == OP_START)       state_nxt = S_RUN;
          else if (cmd_op == OP_DISARM) state_nxt = S_IDLE;
          else                          cmd_ill   = 1'b1;
        end
        S_RUN: begin
          if (cmd_op == OP_STOP)        state_nxt = S_ARMED;
          else if (cmd_op == OP_DISARM) state_nxt = S_IDLE;
          else                          cmd_ill   = 1'b1;
        end
        S_DONE: begin
          if (cmd_op == OP_START)       state_nxt = S_RUN;
          else if (cmd_op == OP_STOP)   state_nxt = S_ARMED;
          else if (cmd_op == OP_DISARM) state_nxt = S_IDLE;
          else                          cmd_ill   = 1'b1;
        end
        default: cmd_ill = 1'b1;
      endcase
    end
    // A legal STOP/DISARM on the final boundary takes precedence over DONE;
    // an illegal command leaves the boundary's DONE transition intact.
    if (boundary && !(accept && !cmd_ill) && (act_rpt != '0) && (cyc_inc == act_rpt))
      state_nxt = S_DONE;
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sw_en       <= 1'b0;
      sw_run      <= 1'b0;
      cmd_ready   <= 1'b1;
      cmd_err     <= 1'b0;
      done        <= 1'b0;
      cycles_done <= '0;
      m           <= '0;
      init_cyc    <= 1'b0;
      pending     <= 1'b0;
    end else begin
      state     <= state_nxt;
      sw_en     <= (state_nxt != S_IDLE);
      sw_run    <= (state_nxt == S_RUN);
      cmd_ready <= ~accept;
      cmd_err   <= accept & cmd_ill;

      if (start_go || disarm_go)
        done <= 1'b0;
      else if ((state_nxt == S_DONE) && (state != S_DONE))
        done <= 1'b1;

      if (start_go)
        cycles_done <= '0;
      else if (boundary)
        cycles_done <= cyc_inc;

      if ((state_nxt == S_RUN) && (state != S_RUN)) begin
        m        <= '0;
        init_cyc <= 1'b1;
      end else if ((state_nxt == S_RUN) && (state == S_RUN)) begin
        init_cyc <= 1'b0;
        if (init_cyc || boundary) m <= '0;
        else                      m <= m + DATA_W'(1);
      end else begin
        m        <= '0;
        init_cyc <= 1'b0;
      end

      // A write on a commit edge lands after the copy, so it stays pending.
      if (cfg_we)      pending <= 1'b1;
      else if (commit) pending <= 1'b0;
    end
  end

  // Timing table banks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_beg    <= '0;
      sh_end    <= '0;
      sh_io     <= '0;
      sh_max    <= '0;
      sh_rpt    <= '0;
      cnt_beg   <= '0;
      cnt_end   <= '0;
      io_init   <= '0;
      max_count <= '0;
      act_rpt   <= '0;
    end else begin
      if (commit) begin
        cnt_beg   <= sh_beg;
        cnt_end   <= sh_end;
        io_init   <= sh_io;
        max_count <= sh_max;
        act_rpt   <= sh_rpt;
      end
      if (cfg_we) begin
        for (int i = 0; i < NCH; i++) begin
          if (cfg_addr == 6'(i))       sh_beg[i] <= cfg_wdata;
          if (cfg_addr == 6'(NCH + i)) sh_end[i] <= cfg_wdata;
        end
        if (cfg_addr == ADDR_IO)  sh_io  <= cfg_wdata;
        if (cfg_addr == ADDR_MAX) sh_max <= cfg_wdata;
        if (cfg_addr == ADDR_RPT) sh_rpt <= cfg_wdata;
      end
    end
  end

endmodule
